mpr_switch_ctrl: RTL and testbench

- Upstream feeder of the MPR context-parking block. It tracks near-memory address locks held by the running thread and detects a request to an address that is already locked.
- On a conflict it snapshots the 15-word register context and issues a one-cycle context switch, together with the conflicting address.
- When a locked address is released and a thread is parked on it, it emits freed and freed_address so MPR can unlock the matching slot.
- It also enforces MPR's 4-slot capacity by stalling requests.

---
 rtl/mpr_switch_ctrl_if.sv | 25 ++
 rtl/mpr_switch_ctrl.sv | 93 +++++++++
 tb/tb_mpr_switch_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mpr_switch_ctrl_if.sv
// mpr_switch_ctrl_if: request, release and context-switch signals between a thread front end and mpr_switch_ctrl
interface mpr_switch_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic [8:0]   req_addr;
  logic [479:0] regs_in;
  logic         rel_valid;
  logic [8:0]   rel_addr;
  logic         grant;
  logic         context_switch;
  logic [8:0]   cs_address;
  logic [479:0] cs_regs;
  logic         freed;
  logic [8:0]   freed_address;
  logic [2:0]   parked_count;
  logic         rel_err;
  modport master (
    output req_valid, req_addr, regs_in, rel_valid, rel_addr,
    input  req_ready, grant, context_switch, cs_address, cs_regs, freed, freed_address, parked_count, rel_err
  );
  modport slave (
    input  req_valid, req_addr, regs_in, rel_valid, rel_addr,
    output req_ready, grant, context_switch, cs_address, cs_regs, freed, freed_address, parked_count, rel_err
  );
endinterface

// File: rtl/mpr_switch_ctrl.sv
// mpr_switch_ctrl: address lock table that parks conflicting contexts via one-cycle context switches
module mpr_switch_ctrl #(
  parameter int NUM_LOCKS  = 8,
  parameter int MAX_PARKED = 4,
  parameter int HOLDOFF    = 2
) (
  input logic clk,
  input logic rst,
  mpr_switch_ctrl_if.slave io
);
  localparam int IW = NUM_LOCKS > 1 ? $clog2(NUM_LOCKS) : 1;
  localparam logic [2:0] MAXP = 3'(MAX_PARKED);
  typedef enum logic [1:0] {IDLE, SWITCH, HOLD} state_t;
  state_t state, state_nx;
  logic [2:0] hcnt, hcnt_nx;
  logic [8:0] addr [NUM_LOCKS];
  logic [NUM_LOCKS-1:0] vld, wtr, rel_hit, req_hit, v_eff, alloc_mask;
  logic [IW-1:0] free_idx;
  logic en, rel_wt, any_rel, hit, hit_wt, full, stall, acc, conflict, alloc;
  logic [2:0] pc_eff;
  // Release is resolved first so the request sees the post-release table and parked count.
  always_comb begin
    rel_hit  = '0;
    req_hit  = '0;
    free_idx = '0;
    for (int i = 0; i < NUM_LOCKS; i++) rel_hit[i] = io.rel_valid && vld[i] && addr[i] == io.rel_addr;
    v_eff = vld & ~rel_hit;
    for (int i = 0; i < NUM_LOCKS; i++) req_hit[i] = v_eff[i] && addr[i] == io.req_addr;
    for (int i = NUM_LOCKS - 1; i >= 0; i--) if (!v_eff[i]) free_idx = IW'(i);
    any_rel    = |rel_hit;
    rel_wt     = |(rel_hit & wtr);
    hit        = |req_hit;
    hit_wt     = |(req_hit & wtr);
    full       = &v_eff;
    pc_eff     = io.parked_count - {2'b0, rel_wt};
    stall      = hit ? (hit_wt || pc_eff >= MAXP) : full;
    io.req_ready = en && state == IDLE && !stall;
    acc        = io.req_valid && io.req_ready;
    conflict   = acc && hit;
    alloc      = acc && !hit;
    alloc_mask = alloc ? NUM_LOCKS'(1) << free_idx : '0;
  end
  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    case (state)
      IDLE:    state_nx = conflict ? SWITCH : IDLE;
      SWITCH: begin
        state_nx = HOLDOFF > 0 ? HOLD : IDLE;
        hcnt_nx  = 3'(HOLDOFF - 1);
      end
      HOLD: begin
        state_nx = hcnt == 3'd0 ? IDLE : HOLD;
        hcnt_nx  = hcnt == 3'd0 ? hcnt : hcnt - 3'd1;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign io.context_switch = state == SWITCH;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      hcnt             <= '0;
      en               <= 1'b0;
      vld              <= '0;
      wtr              <= '0;
      io.grant         <= 1'b0;
      io.freed         <= 1'b0;
      io.freed_address <= '0;
      io.cs_address    <= '0;
      io.cs_regs       <= '0;
      io.parked_count  <= '0;
      io.rel_err       <= 1'b0;
    end else begin
      state    <= state_nx;
      hcnt     <= hcnt_nx;
      en       <= 1'b1;
      vld      <= v_eff | alloc_mask;
      wtr      <= (wtr & ~rel_hit) | (conflict ? req_hit : '0);
      io.grant <= alloc;
      io.freed <= rel_wt;
      if (rel_wt) io.freed_address <= io.rel_addr;
      if (io.rel_valid && !any_rel) io.rel_err <= 1'b1;
      if (conflict) begin
        io.cs_address <= io.req_addr;
        io.cs_regs    <= io.regs_in;
      end
      if (conflict && !rel_wt && io.parked_count < MAXP) io.parked_count <= io.parked_count + 3'd1;
      else if (rel_wt && !conflict && io.parked_count != 3'd0) io.parked_count <= io.parked_count - 3'd1;
    end
  end
  always_ff @(posedge clk) if (alloc) addr[free_idx] <= io.req_addr;
endmodule

// File: tb/tb_mpr_switch_ctrl.sv
// tb_mpr_switch_ctrl: directed stimulus checked every cycle against a set-based lock/park model
module tb_mpr_switch_ctrl;
  localparam int HOLDOFF = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nvec = 0;
  int nerr = 0;
  mpr_switch_ctrl_if io();
  mpr_switch_ctrl #(.NUM_LOCKS(8), .MAX_PARKED(4), .HOLDOFF(HOLDOFF)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  bit lk [512];
  bit wt [512];
  int nlk, pc, busy;
  bit en, e_grant, e_cs, e_freed, e_err;
  logic [8:0] e_fa, e_csa;
  logic [479:0] e_regs;
  function automatic bit m_ready();
    bit rel_lk, hit;
    int n, p;
    rel_lk = io.rel_valid && lk[io.rel_addr];
    hit = lk[io.req_addr] && !(rel_lk && io.rel_addr == io.req_addr);
    n = nlk - int'(rel_lk);
    p = pc - int'(rel_lk && wt[io.rel_addr]);
    return en && busy == 0 && !(hit ? (wt[io.req_addr] || p >= 4) : n >= 8);
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (lk[i]) begin lk[i] = 0; wt[i] = 0; end
      nlk = 0; pc = 0; busy = 0; en = 0;
      e_grant = 0; e_cs = 0; e_freed = 0; e_err = 0; e_fa = '0; e_csa = '0; e_regs = '0;
    end else begin
      bit acc, hit;
      acc = io.req_valid && m_ready();
      hit = lk[io.req_addr] && !(io.rel_valid && io.rel_addr == io.req_addr);
      en = 1; e_grant = 0; e_cs = 0; e_freed = 0;
      if (busy > 0) busy--;
      if (io.rel_valid) begin
        if (lk[io.rel_addr]) begin
          if (wt[io.rel_addr]) begin e_freed = 1; e_fa = io.rel_addr; pc--; end
          lk[io.rel_addr] = 0; wt[io.rel_addr] = 0; nlk--;
        end else e_err = 1;
      end
      if (acc && hit) begin
        wt[io.req_addr] = 1; pc++; e_cs = 1; busy = 1 + HOLDOFF;
        e_csa = io.req_addr; e_regs = io.regs_in;
      end else if (acc) begin
        lk[io.req_addr] = 1; nlk++; e_grant = 1;
      end
    end
  end
  task automatic cmp(input string n, input logic [479:0] a, input logic [479:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    cmp("req_ready", 480'(io.req_ready), 480'(m_ready()));
    cmp("grant", 480'(io.grant), 480'(e_grant));
    cmp("context_switch", 480'(io.context_switch), 480'(e_cs));
    cmp("cs_address", 480'(io.cs_address), 480'(e_csa));
    cmp("cs_regs", io.cs_regs, e_regs);
    cmp("freed", 480'(io.freed), 480'(e_freed));
    cmp("freed_address", 480'(io.freed_address), 480'(e_fa));
    cmp("parked_count", 480'(io.parked_count), 480'(pc));
    cmp("rel_err", 480'(io.rel_err), 480'(e_err));
  end
  task automatic tick(); @(posedge clk); #2; endtask
  task automatic drive(input bit v, input logic [8:0] a, input bit rv, input logic [8:0] ra);
    io.req_valid = v; io.req_addr = a; io.rel_valid = rv; io.rel_addr = ra;
  endtask
  task automatic set_regs(input logic [31:0] base);
    for (int i = 0; i < 15; i++) io.regs_in[32*i +: 32] = base + 32'(i);
  endtask
  task automatic lit(input string n, input logic [479:0] a, input logic [479:0] e);
    cmp({"lit_", n}, a, e);
  endtask
  initial begin
    logic [8:0] rel_list [8];
    rel_list = '{9'h002, 9'h003, 9'h004, 9'h005, 9'h101, 9'h102, 9'h103, 9'h1FF};
    drive(0, 0, 0, 0);
    set_regs(32'h100);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 lit("ready_after_rst", 480'(io.req_ready), 0);
    lit("cs_regs_rst", io.cs_regs, 0);
    tick();
    lit("ready_first_edge", 480'(io.req_ready), 1);
    drive(1, 9'h012, 0, 0);
    tick();
    lit("grant_0x012", 480'(io.grant), 1);
    set_regs(32'hA00);
    tick();
    lit("cs_pulse", 480'(io.context_switch), 1);
    lit("cs_address", 480'(io.cs_address), 480'(9'h012));
    lit("cs_word3", 480'(io.cs_regs[127:96]), 480'(32'hA03));
    lit("parked_1", 480'(io.parked_count), 1);
    lit("ready_sw", 480'(io.req_ready), 0);
    drive(0, 0, 0, 0);
    tick();
    lit("cs_one_cycle", 480'(io.context_switch), 0);
    lit("ready_hold1", 480'(io.req_ready), 0);
    tick();
    lit("ready_hold2", 480'(io.req_ready), 0);
    tick();
    lit("ready_back", 480'(io.req_ready), 1);
    drive(0, 0, 1, 9'h012);
    tick();
    drive(0, 0, 0, 0);
    lit("freed", 480'(io.freed), 1);
    lit("freed_address", 480'(io.freed_address), 480'(9'h012));
    lit("parked_0", 480'(io.parked_count), 0);
    drive(0, 0, 1, 9'h012);
    tick();
    drive(0, 0, 0, 0);
    lit("rel_err", 480'(io.rel_err), 1);
    lit("no_freed", 480'(io.freed), 0);
    for (int a = 1; a <= 4; a++) begin drive(1, 9'(a), 0, 0); tick(); end
    for (int a = 1; a <= 4; a++) begin
      drive(1, 9'(a), 0, 0); tick();
      drive(0, 0, 0, 0); repeat (3) tick();
    end
    lit("parked_4", 480'(io.parked_count), 4);
    drive(1, 9'h005, 0, 0); tick();
    repeat (4) begin
      tick();
      lit("stall_full_park", 480'(io.req_ready), 0);
    end
    drive(1, 9'h005, 1, 9'h001);
    #1 lit("ready_on_release", 480'(io.req_ready), 1);
    tick();
    drive(0, 0, 0, 0);
    lit("fifth_cs", 480'(io.context_switch), 1);
    lit("fifth_freed", 480'(io.freed), 1);
    lit("parked_still_4", 480'(io.parked_count), 4);
    repeat (3) tick();
    for (int a = 0; a < 4; a++) begin drive(1, 9'h100 + 9'(a), 0, 0); tick(); end
    drive(1, 9'h1FF, 0, 0);
    #1 lit("stall_table_full", 480'(io.req_ready), 0);
    tick();
    drive(1, 9'h1FF, 1, 9'h100);
    tick();
    drive(0, 0, 0, 0);
    lit("grant_reused_slot", 480'(io.grant), 1);
    foreach (rel_list[i]) begin drive(0, 0, 1, rel_list[i]); tick(); end
    drive(0, 0, 0, 0); tick();
    lit("parked_cleared", 480'(io.parked_count), 0);
    drive(1, 9'h030, 0, 0); tick();
    tick();
    drive(0, 0, 0, 0); repeat (3) tick();
    drive(1, 9'h030, 0, 0);
    repeat (2) begin
      tick();
      lit("stall_waiter", 480'(io.req_ready), 0);
      lit("no_second_cs", 480'(io.context_switch), 0);
    end
    drive(1, 9'h030, 1, 9'h030);
    tick();
    drive(0, 0, 0, 0);
    lit("same_grant", 480'(io.grant), 1);
    lit("same_freed", 480'(io.freed), 1);
    lit("same_parked0", 480'(io.parked_count), 0);
    tick();
    drive(1, 9'h040, 0, 0); tick();
    tick();
    lit("cs_before_rst", 480'(io.context_switch), 1);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    #1 lit("rst_cs", 480'(io.context_switch), 0);
    lit("rst_parked", 480'(io.parked_count), 0);
    lit("rst_regs", io.cs_regs, 0);
    lit("rst_err", 480'(io.rel_err), 0);
    tick();
    rst = 1'b0;
    tick();
    drive(1, 9'h040, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    lit("grant_after_rst", 480'(io.grant), 1);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
